// File: rtl/uart_tx_mmio_pkg.sv
// Shared types and register map for the memory-mapped UART transmitter.
// Bus path types, window base, register offsets, TX FSM states and STATUS bit positions.
package uart_tx_mmio_pkg;

  localparam int DATA_ADDR_W = 32;
  localparam int DATA_W      = 32;

  typedef logic [DATA_ADDR_W-1:0] DataAddrPath;
  typedef logic [DATA_W-1:0]      DataPath;

  localparam DataAddrPath UART_BASE       = 32'h1000_0000;
  localparam logic [2:0]  UART_TXDATA_OFS = 3'd0;
  localparam logic [2:0]  UART_STATUS_OFS = 3'd4;

  localparam int STATUS_FULL_BIT = 0;
  localparam int STATUS_BUSY_BIT = 1;
  localparam int STATUS_OVF_BIT  = 2;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } UartTxState;

  // Word-granular window match; the base is 8-byte aligned.
  function automatic logic uart_window_hit(input DataAddrPath addr);
    return addr[DATA_ADDR_W-1:3] == UART_BASE[DATA_ADDR_W-1:3];
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter; push is honoured when full only if a pop
// happens in the same cycle, so the count stays unchanged in that case.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS decode with zero-latency read
// data, a byte FIFO, and the transmit FSM with baud counter and shift register.
module uart_tx_mmio
  import uart_tx_mmio_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  DataAddrPath dataAddr,
  input  DataPath     dataOut,
  input  logic        dataWrEnable,
  output logic        uartHit,
  output DataPath     uartRdData,
  output logic        txd
);

  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  UartTxState    state_q;
  logic [BW-1:0] baud_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shift_q;
  logic          txd_q;
  logic          ovf_q, ovf_d;

  logic [2:0]    reg_ofs;
  logic          wr_tx, wr_status;
  logic          baud_done, pop, shift_en, busy;
  logic          fifo_full, fifo_empty;
  logic [7:0]    fifo_rdata;
  logic [CW-1:0] fifo_count;
  logic          unused_bits;

  assign uartHit   = uart_window_hit(dataAddr);
  assign reg_ofs   = {dataAddr[2], 2'b00};
  assign wr_tx     = dataWrEnable && uartHit && (reg_ofs == UART_TXDATA_OFS);
  assign wr_status = dataWrEnable && uartHit && (reg_ofs == UART_STATUS_OFS);

  assign baud_done = (baud_q == BAUD_LAST);
  assign pop       = !fifo_empty && ((state_q == IDLE) || (state_q == STOP && baud_done));
  assign shift_en  = (state_q == DATA) && baud_done && (bit_idx_q != 3'd7);
  assign busy      = !fifo_empty || (state_q != IDLE);
  assign txd       = txd_q;

  assign unused_bits = ^{dataAddr[1:0], dataOut[DATA_W-1:8], fifo_count};

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (wr_tx),
    .pop_i   (pop),
    .wdata_i (dataOut[7:0]),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A write to STATUS wins; a dropped TXDATA byte makes overflow sticky.
  always_comb begin
    ovf_d = ovf_q;
    if (wr_status)                     ovf_d = 1'b0;
    else if (wr_tx && fifo_full && !pop) ovf_d = 1'b1;
  end

  always_comb begin
    uartRdData = '0;
    if (uartHit && reg_ofs == UART_STATUS_OFS) begin
      uartRdData[STATUS_FULL_BIT] = fifo_full;
      uartRdData[STATUS_BUSY_BIT] = busy;
      uartRdData[STATUS_OVF_BIT]  = ovf_q;
    end
  end

  always_ff @(posedge clk) begin
    if (pop)           shift_q <= fifo_rdata;
    else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      txd_q     <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      case (state_q)
        IDLE: begin
          txd_q <= 1'b1;
          if (!fifo_empty) begin
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            txd_q     <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
              txd_q     <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_q <= '0;
            // Back-to-back frames start without an idle bit time.
            if (!fifo_empty) begin
              txd_q   <= 1'b0;
              state_q <= START;
            end else begin
              state_q <= IDLE;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        default: begin
          txd_q   <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_mmio.md
# uart_tx_mmio

Memory-mapped UART transmitter on the CPU data bus, downstream of the single-cycle core. It decodes the core's data address, write data and write enable, and buffers written bytes in a small FIFO. Bytes are serialised as 8N1 frames on `txd`. A combinational status read lets software poll without stalling the core.

## Interface
Parameters:
- `CLKS_PER_BIT`, 16: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, 4: TX FIFO entries. Must be a power of two, ≥ 2.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `dataAddr` in `DataAddrPath`: core data address.
- `dataOut` in `DataPath`: core write data. Only bits [7:0] are used.
- `dataWrEnable` in 1: core store strobe, valid in the same cycle as `dataAddr`.
- `uartHit` out 1: combinational. High when `dataAddr` falls in the UART window.
- `uartRdData` out `DataPath`: combinational read data for the addressed register. 0 when not hit.
- `txd` out 1: serial output. Registered; idles high.

## Operation
- The UART window is `UART_BASE` to `UART_BASE+7`. Decode uses word address; `dataAddr[1:0]` is ignored.
  - `TXDATA` at offset 0.
    - Write pushes `dataOut[7:0]`.
    - Read returns 0.
  - `STATUS` at offset 4. Read returns `{29'b0, overflow, busy, full}`.
    - `full` = FIFO count == `FIFO_DEPTH`.
    - `busy` = FIFO non-empty or FSM not IDLE.
    - `overflow` is sticky.
    - Any write to `STATUS` clears `overflow`; the write data is ignored.
- Push rule: a write to `TXDATA` is accepted when count < `FIFO_DEPTH`, or when a pop occurs in the same cycle. Otherwise the byte is dropped and `overflow` is set.
- Simultaneous push and pop leaves count unchanged.
- Transmit FSM states: IDLE, START, DATA, STOP. One baud counter (0..`CLKS_PER_BIT`-1) and one 3-bit bit index.
  - IDLE:
    - `txd`=1.
    - If FIFO is non-empty: pop the head into the shift register, clear the baud counter, `txd`<=0, go to START.
  - START: after `CLKS_PER_BIT` cycles, `txd`<=bit 0, go to DATA.
  - DATA: shift LSB first. After `CLKS_PER_BIT` cycles at bit index 7, `txd`<=1 and go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles:
    - If FIFO is non-empty: pop, `txd`<=0, go to START. There is no idle gap between frames.
    - Otherwise go to IDLE.
- Reset, including mid-frame:
  - FSM to IDLE, `txd`=1 immediately.
  - FIFO emptied, `overflow`=0, counters 0.
  - Combinational outputs follow from the reset state: `uartRdData` on a STATUS read = 0.

## Timing
- A `TXDATA` write sampled at edge N makes `busy` read 1 from edge N. `txd` falls at edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles, measured from `txd` fall to the start of the next frame or of idle.
- Back-to-back frames have a period of 10×`CLKS_PER_BIT` cycles.
- `uartHit` and `uartRdData` have zero latency, as the single-cycle core requires read data in the same cycle.
- Status bits reflect register state as of the last edge.
- FIFO pointers wrap modulo `FIFO_DEPTH`. Count width is log2(`FIFO_DEPTH`)+1.

## Structure
- Shared package (Types):
  - `UART_BASE`.
  - Register offsets `UART_TXDATA_OFS`=0 and `UART_STATUS_OFS`=4.
  - `UartTxState` enum {IDLE, START, DATA, STOP}.
  - The `STATUS` bit positions.
- Sub-module `uart_tx_fifo`: parameterised byte FIFO with push/pop/full/empty/count, using the same `clk`/`rst`.
- The top level holds the decode, the FSM, the baud counter and the shift register.

## Test plan
Directed tests use `CLKS_PER_BIT`=4 and `FIFO_DEPTH`=4.
- Reset idle: assert `rst` for 3 cycles, then release.
  - `txd`=1, STATUS read = 0x0, `uartHit`=0 for an address outside the window.
- Single byte: write 0xA5 to `TXDATA`.
  - `txd` falls one cycle later.
  - Sampled mid-bit, the bits are 0,1,0,1,0,0,1,0,1,1.
  - `txd` is high after 40 cycles and STATUS returns 0x0.
- Back-to-back: write 0x01, 0x02 and 0x03 on consecutive cycles.
  - Three frames, 120 cycles total, with no idle gap between them.
  - `full` never sets.
- Overflow: write 6 bytes on consecutive cycles starting at IDLE. The first is popped on the next edge, so 5 are accepted and 1 is dropped.
  - STATUS reads 0x7 while full.
  - Writing `STATUS` reads back bit2=0 afterwards.
- Full with simultaneous pop: hold the FIFO full at STOP end, then write `TXDATA` in the pop cycle.
  - Byte accepted, `overflow` stays 0.
- Reset mid-frame: assert `rst` during DATA bit 3.
  - `txd`=1 in the same cycle, without waiting for an edge.
  - After release, STATUS = 0x0 and no residual frame is sent.
